// File: rtl/clk_divider_by_n.sv
// Programmable clock divider: wrapping counter, registered divided clock and period-end pulse.
// Divisor changes are staged in a pending register and applied only at a period boundary or while gated.
module clk_divider_by_n #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clk_en,
   input  logic             i_count_valid,
   input  logic [WIDTH-1:0] i_div,
   input  logic             i_div_load,
   output logic             o_div_busy,
   output logic             o_div_err,
   output logic [WIDTH-1:0] o_count,
   output logic             o_count_end,
   output logic             o_div_clk
);

   if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default_div
      $error("DEFAULT_DIV out of range for WIDTH");
   end

   localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
   localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);

   typedef enum logic {
      ST_IDLE,
      ST_PENDING
   } state_t;

   state_t           state_r, state_nx;
   logic [WIDTH-1:0] div_r, div_nx;
   logic [WIDTH-1:0] pending_r, pending_nx;
   logic [WIDTH-1:0] count_nx;
   logic             err_nx;
   logic             count_end_nx;
   logic             div_clk_nx;
   logic             advance;
   logic             wrap;

   assign advance = i_clk_en & i_count_valid;
   // count < div_r always holds, so div_r-1 never underflows and count+1 never overflows.
   assign wrap    = advance && (o_count == div_r - WIDTH'(1));

   assign o_div_busy = (state_r == ST_PENDING);

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      state_nx   = state_r;
      div_nx     = div_r;
      pending_nx = pending_r;
      err_nx     = o_div_err;
      count_nx   = o_count;

      if (advance) begin
         count_nx = wrap ? '0 : o_count + WIDTH'(1);
      end

      unique case (state_r)
         ST_IDLE: begin
            if (i_div_load) begin
               if (i_div >= DIV_MIN) begin
                  pending_nx = i_div;
                  err_nx     = 1'b0;
                  state_nx   = ST_PENDING;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         ST_PENDING: begin
            // Loads are ignored here; the staged divisor lands at a period boundary only.
            if (!i_clk_en) begin
               div_nx   = pending_r;
               count_nx = '0;
               state_nx = ST_IDLE;
            end else if (wrap) begin
               div_nx   = pending_r;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      count_end_nx = wrap;
      // Compare against the values the flops will hold, so o_div_clk tracks o_count in the same cycle.
      div_clk_nx   = (count_nx >= (div_nx >> 1));
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch and wins over all other updates.
      if (reset) begin
         state_r     <= ST_IDLE;
         div_r       <= DIV_RESET;
         pending_r   <= DIV_RESET;
         o_div_err   <= 1'b0;
         o_count     <= '0;
         o_count_end <= 1'b0;
         o_div_clk   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_r     <= state_nx;
         div_r       <= div_nx;
         pending_r   <= pending_nx;
         o_div_err   <= err_nx;
         o_count     <= count_nx;
         o_count_end <= count_end_nx;
         o_div_clk   <= div_clk_nx;
      end
   end

endmodule

// File: tb/tb_clk_divider_by_n.sv
// Table-driven bench for clk_divider_by_n: per-cycle vectors with hand-computed outputs,
// plus a bounded period/duty measurement.
module tb_clk_divider_by_n;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_clk_en;
   logic             i_count_valid;
   logic [WIDTH-1:0] i_div;
   logic             i_div_load;
   logic             o_div_busy;
   logic             o_div_err;
   logic [WIDTH-1:0] o_count;
   logic             o_count_end;
   logic             o_div_clk;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   clk_divider_by_n #(.WIDTH(WIDTH), .DEFAULT_DIV(7)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_clk_en     (i_clk_en),
      .i_count_valid(i_count_valid),
      .i_div        (i_div),
      .i_div_load   (i_div_load),
      .o_div_busy   (o_div_busy),
      .o_div_err    (o_div_err),
      .o_count      (o_count),
      .o_count_end  (o_count_end),
      .o_div_clk    (o_div_clk)
   );

   typedef struct {
      logic             rst;
      logic             en;
      logic             valid;
      logic             load;
      logic [WIDTH-1:0] div;
      logic [WIDTH-1:0] cnt;
      logic             cend;
      logic             dclk;
      logic             busy;
      logic             err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic en, input logic valid, input logic load,
                      input int div, input int cnt, input logic cend, input logic dclk,
                      input logic busy, input logic err);
      vec_t v;
      v.rst = rst; v.en = en; v.valid = valid; v.load = load;
      v.div = WIDTH'(div); v.cnt = WIDTH'(cnt);
      v.cend = cend; v.dclk = dclk; v.busy = busy; v.err = err;
      vecs.push_back(v);
   endtask

   // Plain advance row with no load: expected count, end pulse, divided clock, busy, err.
   task automatic adv(input int cnt, input logic cend, input logic dclk,
                      input logic busy, input logic err);
      add(1'b0, 1'b1, 1'b1, 1'b0, 0, cnt, cend, dclk, busy, err);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      int   period;
      int   high;
      logic got_end;

      reset = 1'b1; i_clk_en = 1'b0; i_count_valid = 1'b0; i_div = '0; i_div_load = 1'b0;

      // Reset held three cycles
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Continuous advance with divisor 7: two full periods, 3 low / 4 high
      for (int r = 0; r < 2; r++) begin
         adv(1, 0, 0, 0, 0); adv(2, 0, 0, 0, 0); adv(3, 0, 1, 0, 0);
         adv(4, 0, 1, 0, 0); adv(5, 0, 1, 0, 0); adv(6, 0, 1, 0, 0);
         adv(0, 1, 0, 0, 0);
      end
      // Count-valid stall at 4 for five cycles, then one gated cycle, then resume
      adv(1, 0, 0, 0, 0); adv(2, 0, 0, 0, 0); adv(3, 0, 1, 0, 0); adv(4, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 4, 0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 4, 0, 1, 0, 0);
      adv(5, 0, 1, 0, 0); adv(6, 0, 1, 0, 0); adv(0, 1, 0, 0, 0); adv(1, 0, 0, 0, 0);
      // Reset at count 5 restarts; first advance after release gives 1
      adv(2, 0, 0, 0, 0); adv(3, 0, 1, 0, 0); adv(4, 0, 1, 0, 0); adv(5, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      adv(1, 0, 0, 0, 0); adv(2, 0, 0, 0, 0);
      // Load 4 at count 2: current 7-period completes, then 2 low / 2 high
      add(0, 1, 1, 1, 4, 3, 0, 1, 1, 0);
      adv(4, 0, 1, 1, 0); adv(5, 0, 1, 1, 0); adv(6, 0, 1, 1, 0); adv(0, 1, 0, 0, 0);
      for (int r = 0; r < 2; r++) begin
         adv(1, 0, 0, 0, 0); adv(2, 0, 1, 0, 0); adv(3, 0, 1, 0, 0); adv(0, 1, 0, 0, 0);
      end
      // Illegal load 1 sets err and keeps period 7; legal load 3 clears err
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 1, 1, 0, 0, 0, 1);
      adv(2, 0, 0, 0, 1); adv(3, 0, 1, 0, 1); adv(4, 0, 1, 0, 1);
      adv(5, 0, 1, 0, 1); adv(6, 0, 1, 0, 1); adv(0, 1, 0, 0, 1);
      add(0, 1, 1, 1, 3, 1, 0, 0, 1, 0);
      adv(2, 0, 0, 1, 0); adv(3, 0, 1, 1, 0); adv(4, 0, 1, 1, 0);
      adv(5, 0, 1, 1, 0); adv(6, 0, 1, 1, 0); adv(0, 1, 0, 0, 0);
      for (int r = 0; r < 2; r++) begin
         adv(1, 0, 1, 0, 0); adv(2, 0, 1, 0, 0); adv(0, 1, 0, 0, 0);
      end
      // Gated load of 5 at count 5 applies at once; loads during busy are ignored
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      adv(1, 0, 0, 0, 0); adv(2, 0, 0, 0, 0); adv(3, 0, 1, 0, 0);
      adv(4, 0, 1, 0, 0); adv(5, 0, 1, 0, 0);
      add(0, 0, 1, 1, 5, 5, 0, 1, 1, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 2, 1, 0, 0, 1, 0);
      add(0, 1, 1, 1, 9, 2, 0, 1, 1, 0);
      add(0, 1, 1, 1, 0, 3, 0, 1, 1, 0);
      adv(4, 0, 1, 1, 0); adv(0, 1, 0, 0, 0);
      adv(1, 0, 1, 0, 0); adv(0, 1, 0, 0, 0); adv(1, 0, 1, 0, 0); adv(0, 1, 0, 0, 0);
      // Reset mid-pending (with a load and advance in the same cycle) restores divisor 7
      add(0, 1, 1, 1, 6, 1, 0, 1, 1, 0);
      add(1, 1, 1, 1, 5, 0, 0, 0, 0, 0);
      adv(1, 0, 0, 0, 0); adv(2, 0, 0, 0, 0); adv(3, 0, 1, 0, 0);
      adv(4, 0, 1, 0, 0); adv(5, 0, 1, 0, 0); adv(6, 0, 1, 0, 0);
      // Load accepted on the wrapping edge: wrap uses 7, then gated apply of 4
      add(0, 1, 1, 1, 4, 0, 1, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      adv(1, 0, 0, 0, 0); adv(2, 0, 1, 0, 0); adv(3, 0, 1, 0, 0); adv(0, 1, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset         = vecs[i].rst;
         i_clk_en      = vecs[i].en;
         i_count_valid = vecs[i].valid;
         i_div_load    = vecs[i].load;
         i_div         = vecs[i].div;
         @(posedge clk);
         #1;
         check("count",     i, 32'(o_count),     32'(vecs[i].cnt));
         check("count_end", i, 32'(o_count_end), 32'(vecs[i].cend));
         check("div_clk",   i, 32'(o_div_clk),   32'(vecs[i].dclk));
         check("div_busy",  i, 32'(o_div_busy),  32'(vecs[i].busy));
         check("div_err",   i, 32'(o_div_err),   32'(vecs[i].err));
      end

      // Free-running measurement of one full divide-by-4 period, bounded by a cycle budget
      @(negedge clk);
      reset = 1'b0; i_clk_en = 1'b1; i_count_valid = 1'b1; i_div_load = 1'b0; i_div = '0;
      period  = 0;
      high    = 0;
      got_end = 1'b0;
      for (int c = 0; c < 20 && !got_end; c++) begin
         @(posedge clk);
         #1;
         period++;
         if (o_div_clk) high++;
         if (o_count_end) got_end = 1'b1;
      end
      check("period_end_seen", 0, 32'(got_end), 32'd1);
      check("period_len",      0, 32'(period),  32'd4);
      check("period_high",     0, 32'(high),    32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
